// File: rtl/rx_align_ctrl.sv
// rx_align_ctrl: receive-side alignment and link-status controller for a
// 10GBASE-R PCS. Sits between the block synchroniser and the RX gearbox.
//   - forwards synchroniser slip requests to the gearbox with a minimum
//     spacing, and tracks the gearbox slip position
//   - resets the synchroniser when a whole hunt sweep fails to find lock
//   - once locked, runs a windowed sync-header BER monitor -> hi_ber/link_up
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   header, header_ena  sync header of current block and its qualifier
//   block_lock, slp_in  lock indication / slip request from synchroniser
//   gb_slip, gb_slip_pos  one-cycle slip pulse and current slip position
//   bs_rst              reset to block synchroniser
//   hi_ber, link_up     link status
//   slip_cnt, hunt_fail_cnt  saturating statistics
//   state               0=INIT 1=HUNT 2=LOCKED
module rx_align_ctrl #(
  parameter int SLIP_POSITIONS = 66,
  parameter int SLIP_HOLDOFF   = 16,
  parameter int MAX_HUNT_SLIPS = 132,
  parameter int BS_RST_CYCLES  = 8,
  parameter int BER_WINDOW     = 100000,
  parameter int BER_THRESH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  header,
  input  logic        header_ena,
  input  logic        block_lock,
  input  logic        slp_in,
  output logic        gb_slip,
  output logic [6:0]  gb_slip_pos,
  output logic        bs_rst,
  output logic        hi_ber,
  output logic        link_up,
  output logic [15:0] slip_cnt,
  output logic [7:0]  hunt_fail_cnt,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {INIT = 2'd0, HUNT = 2'd1, LOCKED = 2'd2} state_t;

  localparam int HW = $clog2(SLIP_HOLDOFF + 1);
  localparam int IW = $clog2(BS_RST_CYCLES + 1);
  localparam int SW = $clog2(MAX_HUNT_SLIPS + 1);
  localparam int WW = $clog2(BER_WINDOW);
  localparam int EW = $clog2(BER_THRESH + 1);

  state_t        st;
  logic [HW-1:0] holdoff;
  logic [IW-1:0] init_cnt;
  logic [SW-1:0] hunt_slips;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] err_cnt;

  logic          hunt_timeout, fwd, bad_hdr, win_last, err_hit;
  logic [EW-1:0] err_next;

  assign state = st;

  // Lock has priority over the sweep timeout.
  assign hunt_timeout = (st == HUNT) && !block_lock && (hunt_slips >= SW'(MAX_HUNT_SLIPS));
  // A timing-out hunt drops its slip so gb_slip never lands in INIT.
  assign fwd = slp_in && (holdoff == '0) &&
               ((st == LOCKED) || ((st == HUNT) && !hunt_timeout));

  assign bad_hdr  = header_ena && ((header == 2'b00) || (header == 2'b11));
  assign err_next = (bad_hdr && (err_cnt != EW'(BER_THRESH))) ? err_cnt + EW'(1) : err_cnt;
  assign err_hit  = (err_next == EW'(BER_THRESH));
  assign win_last = (win_cnt == WW'(BER_WINDOW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= INIT;
      bs_rst        <= 1'b1;
      gb_slip       <= 1'b0;
      gb_slip_pos   <= '0;
      hi_ber        <= 1'b0;
      link_up       <= 1'b0;
      slip_cnt      <= '0;
      hunt_fail_cnt <= '0;
      holdoff       <= '0;
      init_cnt      <= '0;
      hunt_slips    <= '0;
      win_cnt       <= '0;
      err_cnt       <= '0;
    end else begin
      gb_slip <= fwd;
      if (fwd) begin
        // The timer includes the slip cycle itself, so accepted slips are
        // exactly SLIP_HOLDOFF cycles apart at the fastest.
        holdoff     <= HW'(SLIP_HOLDOFF - 1);
        gb_slip_pos <= (gb_slip_pos == 7'(SLIP_POSITIONS - 1)) ? 7'd0 : gb_slip_pos + 7'd1;
        if (slip_cnt != 16'hFFFF) slip_cnt <= slip_cnt + 16'd1;
      end else if (holdoff != '0) begin
        holdoff <= holdoff - HW'(1);
      end

      case (st)
        INIT: begin
          if (init_cnt == IW'(BS_RST_CYCLES - 1)) begin
            st       <= HUNT;
            bs_rst   <= 1'b0;
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + IW'(1);
          end
        end
        HUNT: begin
          if (block_lock) begin
            st         <= LOCKED;
            hunt_slips <= '0;
            win_cnt    <= '0;
            err_cnt    <= '0;
          end else if (hunt_timeout) begin
            st         <= INIT;
            bs_rst     <= 1'b1;
            init_cnt   <= '0;
            hunt_slips <= '0;
            if (hunt_fail_cnt != 8'hFF) hunt_fail_cnt <= hunt_fail_cnt + 8'd1;
          end else if (fwd) begin
            hunt_slips <= hunt_slips + SW'(1);
          end
        end
        LOCKED: begin
          if (!block_lock || slp_in) begin
            st         <= HUNT;
            hi_ber     <= 1'b0;
            link_up    <= 1'b0;
            // A slip forwarded on the way out is the first one of the new hunt.
            hunt_slips <= SW'(fwd);
          end else if (win_last) begin
            // The final cycle's header still counts toward this window.
            win_cnt <= '0;
            err_cnt <= '0;
            hi_ber  <= err_hit;
            link_up <= !err_hit;
          end else begin
            win_cnt <= win_cnt + WW'(1);
            err_cnt <= err_next;
            if (err_hit) begin
              hi_ber  <= 1'b1;
              link_up <= 1'b0;
            end
          end
        end
        default: begin
          st       <= INIT;
          bs_rst   <= 1'b1;
          init_cnt <= '0;
        end
      endcase
    end
  end
endmodule
